uart_rx_frame: RTL and testbench

Serial-to-byte receive stage of the UART path. It consumes the one-cycle falling-edge pulse produced by the start-edge detector on the RX line, times the frame, and samples the start bit, 8 data bits (LSB first) and 1 stop bit at mid-bit. It outputs each completed byte with a one-cycle valid strobe, or a frame-error strobe when the stop bit is bad. It feeds the host command/data loader of the accelerator.

---
 rtl/uart_rx_frame.sv | 94 +++++++++
 tb/tb_uart_rx_frame.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// UART receive framer: times a frame from the start-edge pulse and samples
// start, 8 data bits (LSB first) and stop at mid-bit, emitting byte or error strobes.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx_pin,
    input  logic       start_det,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    sh;

    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_det) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    // A line back high at mid-start-bit is treated as a glitch.
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_pin) begin
                            state <= DATA;
                            idx   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        sh  <= {rx_pin, sh[7:1]};
                        cnt <= '0;
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Leave at mid-stop-bit so half a bit remains to catch the next start.
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (rx_pin) begin
                            rx_data  <= sh;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed and randomized frames against an arithmetic timing/byte model of the receiver.
module tb_uart_rx_frame;
    localparam int CPB  = 16;
    localparam int HALF = 8;
    localparam int STROBE_OFS = HALF + 9 * CPB;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_pin = 1'b1;
    logic       start_det = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busy_hi = 0;
    int both_hi = 0;

    int         got_t[$], exp_t[$];
    int         got_k[$], exp_k[$];
    logic [7:0] got_d[$], exp_d[$];
    logic [7:0] last_good = 8'h00;

    uart_rx_frame #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
        .clock(clock), .reset_n(reset_n), .rx_pin(rx_pin), .start_det(start_det),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Record strobes with the index of the edge that launched them.
    always @(posedge clock) begin
        #1;
        if (busy) busy_hi++;
        if (rx_valid && frame_err) both_hi++;
        if (rx_valid || frame_err) begin
            got_t.push_back(cyc);
            got_k.push_back(rx_valid ? 1 : 2);
            got_d.push_back(rx_data);
        end
    end

    // One line cycle; start_det mimics the edge detector, plus an optional stray pulse.
    task automatic cyc1(input logic v, input logic extra);
        start_det = (rx_pin & ~v) | extra;
        rx_pin = v;
        @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int gap, input logic inject);
        int e0;
        e0 = cyc + 1;
        for (int j = 0; j < CPB; j++) cyc1(1'b0, 1'b0);
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < CPB; j++) cyc1(b[k], inject && j == 3);
        for (int j = 0; j < CPB; j++) cyc1(stop, inject && j == 2);
        if (stop) last_good = b;
        exp_t.push_back(e0 + STROBE_OFS);
        exp_k.push_back(stop ? 1 : 2);
        exp_d.push_back(last_good);
        for (int j = 0; j < gap; j++) cyc1(1'b1, 1'b0);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_events(input string tag);
        while (exp_t.size() != 0) begin
            checks++;
            assert (got_t.size() != 0) else begin
                failures++;
                $error("FAIL %s_missing observed=none expected_edge=%0d", tag, exp_t[0]);
            end
            if (got_t.size() != 0) begin
                chk({tag, "_time"}, got_t.pop_front(), exp_t[0]);
                chk({tag, "_kind"}, got_k.pop_front(), exp_k[0]);
                chk({tag, "_data"}, int'(got_d.pop_front()), int'(exp_d[0]));
            end
            void'(exp_t.pop_front());
            void'(exp_k.pop_front());
            void'(exp_d.pop_front());
        end
        chk({tag, "_extra_strobes"}, got_t.size(), 0);
        got_t.delete(); got_k.delete(); got_d.delete();
    endtask

    initial begin
        int b0;
        logic [7:0] rb;
        logic rs;
        int rg;

        #1;
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_busy", int'(busy), 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) cyc1(1'b1, 1'b0);

        // Single good frame with busy duration.
        b0 = busy_hi;
        send_frame(8'hA5, 1'b1, 4, 1'b0);
        chk("a5_busy_cycles", busy_hi - b0, STROBE_OFS);
        check_events("a5");
        chk("a5_rx_data", int'(rx_data), 8'hA5);

        // Back-to-back at line rate.
        send_frame(8'h00, 1'b1, 0, 1'b0);
        send_frame(8'hFF, 1'b1, 4, 1'b0);
        check_events("b2b");
        chk("b2b_hold", int'(rx_data), 8'hFF);

        // 3-cycle glitch, then a real start the cycle after the return to IDLE.
        b0 = busy_hi;
        for (int j = 0; j < 3; j++) cyc1(1'b0, 1'b0);
        for (int j = 0; j < 6; j++) cyc1(1'b1, 1'b0);
        chk("glitch_busy_cycles", busy_hi - b0, HALF);
        chk("glitch_idle", int'(busy), 0);
        chk("glitch_rx_data", int'(rx_data), 8'hFF);
        send_frame(8'h3C, 1'b1, 4, 1'b0);
        check_events("glitch");

        // Good frame then bad stop bit.
        send_frame(8'h5A, 1'b1, 2, 1'b0);
        send_frame(8'h77, 1'b0, 4, 1'b0);
        check_events("ferr");
        chk("ferr_rx_data", int'(rx_data), 8'h5A);

        // Reset in the middle of data bit 4 of 0xC3.
        rb = 8'hC3;
        for (int j = 0; j < CPB; j++) cyc1(1'b0, 1'b0);
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < CPB; j++) cyc1(rb[k], 1'b0);
        for (int j = 0; j < CPB / 2; j++) cyc1(rb[4], 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_rx_data", int'(rx_data), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_strobes", int'(rx_valid | frame_err), 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        last_good = 8'h00;
        for (int j = 0; j < 40; j++) cyc1(1'b1, 1'b0);
        check_events("mid_rst");
        send_frame(8'h81, 1'b1, 4, 1'b0);
        check_events("after_rst");
        chk("after_rst_rx_data", int'(rx_data), 8'h81);

        // Stray start pulses during DATA and STOP.
        send_frame(8'h96, 1'b1, 4, 1'b1);
        check_events("inject");
        chk("inject_rx_data", int'(rx_data), 8'h96);

        // Random frames, stop bits and inter-frame gaps.
        for (int n = 0; n < 10; n++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            rg = $urandom_range(0, 5);
            if (!rs && rg == 0) rg = 1;
            send_frame(rb, rs, rg, 1'($urandom_range(0, 1)));
        end
        for (int j = 0; j < 4; j++) cyc1(1'b1, 1'b0);
        check_events("rand");
        chk("rand_rx_data", int'(rx_data), int'(last_good));
        chk("never_both_strobes", both_hi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
